mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Wishbone classic load/store unit: lane placement, read extension and bus timeout.
// Optional macro MISALIGNED_TRAP_EN traps misaligned requests instead of aligning them.
module mem_access_unit #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [2:0]             size,
  input  logic [DATA_SIZE-1:0]   addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   bus_error,
  output logic                   misaligned,
  output logic                   cyc_o,
  output logic                   stb_o,
  output logic                   we_o,
  output logic [DATA_SIZE-1:0]   adr_o,
  output logic [DATA_SIZE/8-1:0] sel_o,
  output logic [DATA_SIZE-1:0]   dat_o,
  input  logic [DATA_SIZE-1:0]   dat_i,
  input  logic                   ack_i
);

  localparam int unsigned SEL_W   = DATA_SIZE / 8;
  localparam int unsigned OFF_W   = $clog2(SEL_W);
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [1:0]  FULL_LG = 2'(OFF_W);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               we_q;
  logic               sext_q;
  logic [1:0]         lg_q;
  logic [OFF_W-1:0]   off_q;

  logic [1:0]           lg_c;
  logic [OFF_W-1:0]     amask_c;
  logic [OFF_W-1:0]     off_c;
  logic [OFF_W-1:0]     off_al_c;
  logic [SEL_W-1:0]     smask_c;
  logic [DATA_SIZE-1:0] shifted_c;
  logic [DATA_SIZE-1:0] low_mask_c;
  logic [DATA_SIZE-1:0] sign_mask_c;
  logic [DATA_SIZE-1:0] rd_ext_c;

  // Request decode: log2 of access bytes, alignment mask and lane mask.
  always_comb begin
    lg_c = size[1:0];
    if (lg_c > FULL_LG || size == 3'b111) lg_c = FULL_LG;
    amask_c  = ~({OFF_W{1'b1}} << lg_c);
    off_c    = addr[OFF_W-1:0];
    off_al_c = off_c & ~amask_c;
    smask_c  = ~({SEL_W{1'b1}} << (4'd1 << lg_c));
  end

  // Read path: move the addressed lanes down, then sign- or zero-extend.
  always_comb begin
    shifted_c   = dat_i >> {off_q, 3'b000};
    low_mask_c  = ~({DATA_SIZE{1'b1}} << (7'd8 << lg_q));
    sign_mask_c = low_mask_c ^ (low_mask_c >> 1);
    rd_ext_c    = shifted_c & low_mask_c;
    if (sext_q && |(shifted_c & sign_mask_c)) rd_ext_c = rd_ext_c | ~low_mask_c;
  end

`ifdef MISALIGNED_TRAP_EN
  logic misaligned_q;
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      lg_q      <= '0;
      off_q     <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_error <= 1'b0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      sel_o     <= '0;
      dat_o     <= '0;
`ifdef MISALIGNED_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            we_q     <= wr_en;
            sext_q   <= ~size[2];
            lg_q     <= lg_c;
            off_q    <= off_al_c;
            wait_cnt <= '0;
`ifdef MISALIGNED_TRAP_EN
            if (|(off_c & amask_c)) begin
              state        <= RESP;
              done         <= 1'b1;
              misaligned_q <= 1'b1;
            end else
`endif
            begin
              state <= BUS;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              busy  <= 1'b1;
              we_o  <= wr_en;
              adr_o <= {addr[DATA_SIZE-1:OFF_W], OFF_W'(0)};
              sel_o <= smask_c << off_al_c;
              dat_o <= wr_data << {off_al_c, 3'b000};
            end
          end
        end
        BUS: begin
          // Ack takes priority over a coincident timeout.
          if (ack_i) begin
            state <= RESP;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!we_q) rd_data <= rd_ext_c;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= RESP;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          done      <= 1'b0;
          bus_error <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
          misaligned_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
